// File: rtl/arc4_pkg.sv
// Shared definitions for the ARC4 init/KSA stage: FSM states, memory/key
// geometry and the key-byte selector used by the key-scheduling datapath.
package arc4_pkg;

    localparam int unsigned MEM_DEPTH = 256;
    localparam int unsigned KEY_BYTES = 3;

    typedef enum logic [3:0] {
        INIT   = 4'd0,
        READI  = 4'd1,
        WAITI  = 4'd2,
        GETJ   = 4'd3,
        READJ  = 4'd4,
        WAITJ  = 4'd5,
        WRITEI = 4'd6,
        WRITEJ = 4'd7,
        DONE   = 4'd8
    } state_e;

    // Key bytes are consumed big-endian: index 0 takes the top byte of the key.
    function automatic logic [7:0] key_byte(input logic [7:0] idx, input logic [23:0] key);
        logic [7:0] sel_s;
        logic [7:0] byte_s;
        sel_s = idx % 8'(KEY_BYTES);
        case (sel_s)
            8'd0:    byte_s = key[23:16];
            8'd1:    byte_s = key[15:8];
            8'd2:    byte_s = key[7:0];
            default: byte_s = 8'h00;
        endcase
        return byte_s;
    endfunction

endpackage

// File: rtl/arc4_ksa.sv
// ARC4 key-scheduling FSM: seven cycles per index to read S[i], update j,
// read S[j] and swap the two entries through a single-port memory.
module arc4_ksa
    import arc4_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [23:0] key,
    input  logic [7:0]  rddata,
    output logic [7:0]  addr,
    output logic [7:0]  data,
    output logic        wren,
    output logic        done
);

    state_e     state_r, state_n;
    logic [7:0] i_r, i_n;
    logic [7:0] j_r, j_n;
    logic [7:0] temp_i_r, temp_i_n;
    logic [7:0] addr_r, addr_n;
    logic [7:0] data_r, data_n;
    logic       wren_r, wren_n;
    logic       done_r, done_n;
    logic [7:0] j_sum_s;

    assign j_sum_s = j_r + rddata + key_byte(i_r, key);

    assign addr = addr_r;
    assign data = data_r;
    assign wren = wren_r;
    assign done = done_r;

    // State and memory-port registers; the port is set on entry to each state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= INIT;
            i_r      <= 8'd0;
            j_r      <= 8'd0;
            temp_i_r <= 8'd0;
            addr_r   <= 8'd0;
            data_r   <= 8'd0;
            wren_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_n;
            i_r      <= i_n;
            j_r      <= j_n;
            temp_i_r <= temp_i_n;
            addr_r   <= addr_n;
            data_r   <= data_n;
            wren_r   <= wren_n;
            done_r   <= done_n;
        end
    end

    // Next-state and next-port logic.
    always_comb begin
        state_n  = state_r;
        i_n      = i_r;
        j_n      = j_r;
        temp_i_n = temp_i_r;
        addr_n   = addr_r;
        data_n   = data_r;
        wren_n   = 1'b0;
        done_n   = done_r;
        case (state_r)
            INIT: begin
                if (start) begin
                    state_n = READI;
                    addr_n  = i_r;
                end else begin
                    state_n = INIT;
                end
            end
            READI: state_n = WAITI;
            WAITI: state_n = GETJ;
            GETJ: begin
                // rddata holds S[i] here; the new j goes straight onto the address bus.
                temp_i_n = rddata;
                j_n      = j_sum_s;
                addr_n   = j_sum_s;
                state_n  = READJ;
            end
            READJ: state_n = WAITJ;
            WAITJ: begin
                addr_n  = i_r;
                data_n  = rddata;
                wren_n  = 1'b1;
                state_n = WRITEI;
            end
            WRITEI: begin
                addr_n  = j_r;
                data_n  = temp_i_r;
                wren_n  = 1'b1;
                state_n = WRITEJ;
            end
            WRITEJ: begin
                if (i_r == 8'hFF) begin
                    done_n  = 1'b1;
                    state_n = DONE;
                end else begin
                    i_n     = i_r + 8'd1;
                    addr_n  = i_r + 8'd1;
                    state_n = READI;
                end
            end
            DONE: begin
                done_n  = 1'b1;
                state_n = DONE;
            end
            default: begin
                state_n = INIT;
            end
        endcase
    end

endmodule

// File: rtl/arc4_init_ksa_top.sv
// DE1-SoC top for ARC4 stage 2: fills S with the identity permutation, then
// hands the memory port to the KSA engine, keyed from the slide switches.
module arc4_init_ksa_top
    import arc4_pkg::*;
(
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [3:0] KEY,
    input  logic [9:0] SW,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5,
    output logic [9:0] LEDR
);

    logic [7:0]  mem_r [0:MEM_DEPTH-1];
    logic [7:0]  rddata_r;

    logic [7:0]  init_cnt_r;
    logic [7:0]  init_addr_r;
    logic [7:0]  init_data_r;
    logic        init_wren_r;
    logic        init_done_r;
    logic        init_last_s;

    logic [7:0]  ksa_addr_s;
    logic [7:0]  ksa_data_s;
    logic        ksa_wren_s;
    logic        ksa_done_s;

    logic [7:0]  mem_addr_s;
    logic [7:0]  mem_data_s;
    logic        mem_wren_s;
    logic [23:0] key_s;
    logic        unused_key_s;

    assign key_s        = {14'b0, SW};
    assign unused_key_s = ^KEY;

    // The write of address 255 commits on the same edge that hands over to the KSA.
    assign init_last_s = init_wren_r && (init_addr_r == 8'hFF);

    // Init pass: one identity write per cycle until address 255 has been written.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            init_cnt_r  <= 8'd0;
            init_addr_r <= 8'd0;
            init_data_r <= 8'd0;
            init_wren_r <= 1'b0;
            init_done_r <= 1'b0;
        end else if (init_done_r) begin
            init_wren_r <= 1'b0;
        end else if (init_last_s) begin
            init_wren_r <= 1'b0;
            init_done_r <= 1'b1;
        end else begin
            init_addr_r <= init_cnt_r;
            init_data_r <= init_cnt_r;
            init_wren_r <= 1'b1;
            init_cnt_r  <= init_cnt_r + 8'd1;
        end
    end

    arc4_ksa u_ksa (
        .clk    (CLOCK_50),
        .reset  (reset),
        .start  (init_last_s),
        .key    (key_s),
        .rddata (rddata_r),
        .addr   (ksa_addr_s),
        .data   (ksa_data_s),
        .wren   (ksa_wren_s),
        .done   (ksa_done_s)
    );

    // Memory port ownership: init engine until it finishes, KSA afterwards.
    always_comb begin
        mem_addr_s = init_addr_r;
        mem_data_s = init_data_r;
        mem_wren_s = init_wren_r;
        if (init_done_r) begin
            mem_addr_s = ksa_addr_s;
            mem_data_s = ksa_data_s;
            mem_wren_s = ksa_wren_s;
        end else begin
            mem_addr_s = init_addr_r;
            mem_data_s = init_data_r;
            mem_wren_s = init_wren_r;
        end
    end

    // Single-port state memory with registered read (read-before-write).
    always_ff @(posedge CLOCK_50) begin
        if (mem_wren_s) begin
            mem_r[mem_addr_s] <= mem_data_s;
        end
        rddata_r <= mem_r[mem_addr_s];
    end

    assign HEX0 = 7'h7F;
    assign HEX1 = 7'h7F;
    assign HEX2 = 7'h7F;
    assign HEX3 = 7'h7F;
    assign HEX4 = 7'h7F;
    assign HEX5 = 7'h7F;
    assign LEDR = {8'b0, init_done_r, ksa_done_s};

endmodule

// File: tb/tb_arc4_init_ksa_top.sv
// Randomized self-checking bench: compares init writes, per-iteration KSA
// port activity and final S against a plain array model of ARC4 KSA.
module tb_arc4_init_ksa_top;
    import arc4_pkg::*;

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b1;
    logic [3:0] KEY      = 4'hF;
    logic [9:0] SW       = 10'd0;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
    logic [9:0] LEDR;

    int n_vec = 0;
    int n_err = 0;
    int s_model [256];
    int kb [3];

    always #10 CLOCK_50 = ~CLOCK_50;

    arc4_init_ksa_top dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .KEY      (KEY),
        .SW       (SW),
        .HEX0     (HEX0),
        .HEX1     (HEX1),
        .HEX2     (HEX2),
        .HEX3     (HEX3),
        .HEX4     (HEX4),
        .HEX5     (HEX5),
        .LEDR     (LEDR)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_state(input state_e tgt, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 16; c++) begin
            @(negedge CLOCK_50);
            if (dut.u_ksa.state_r == tgt) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_eq("wait_state", 64'(dut.u_ksa.state_r), 64'(tgt));
    endtask

    task automatic do_reset(input logic [9:0] sw);
        @(negedge CLOCK_50);
        SW    = sw;
        reset = 1'b1;
        @(negedge CLOCK_50);
        check_eq("rst_state", 64'(dut.u_ksa.state_r), 64'(INIT));
        check_eq("rst_ijt", {dut.u_ksa.i_r, dut.u_ksa.j_r, dut.u_ksa.temp_i_r}, 64'd0);
        check_eq("rst_wren", 64'(dut.mem_wren_s), 64'd0);
        check_eq("rst_ledr", 64'(LEDR), 64'd0);
        check_eq("rst_hex", {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}, {6{7'h7F}});
        reset = 1'b0;
    endtask

    task automatic run_init();
        int bad;
        for (int k = 0; k < 256; k++) begin
            @(negedge CLOCK_50);
            check_eq($sformatf("init_wr%0d", k),
                     {dut.mem_wren_s, dut.mem_addr_s, dut.mem_data_s, LEDR[1]},
                     {1'b1, 8'(k), 8'(k), 1'b0});
        end
        @(negedge CLOCK_50);
        check_eq("init_done", 64'(LEDR), 64'b10);
        check_eq("init_to_readi", 64'(dut.u_ksa.state_r), 64'(READI));
        bad = 0;
        for (int k = 0; k < 256; k++) begin
            s_model[k] = k;
            if (dut.mem_r[k] !== 8'(k)) bad++;
        end
        check_eq("init_identity_errs", 64'(bad), 64'd0);
        kb[0] = 0;
        kb[1] = int'(SW[9:8]);
        kb[2] = int'(SW[7:0]);
    endtask

    task automatic run_ksa(input int n_iter);
        int j, jn, si, sj, bad, seen;
        bit ok;
        bit hit [256];
        j = 0;
        for (int i = 0; i < n_iter; i++) begin
            si = s_model[i];
            jn = (j + si + kb[i % 3]) % 256;
            sj = s_model[jn];
            wait_state(GETJ, ok);
            if (!ok) return;
            @(negedge CLOCK_50);
            check_eq("readj_addr", {dut.mem_addr_s, dut.mem_wren_s, dut.u_ksa.j_r},
                     {8'(jn), 1'b0, 8'(jn)});
            if (SW == 10'h000 && i == 2) check_eq("sw000_j2", 64'(dut.u_ksa.j_r), 64'd3);
            if (SW == 10'h3FF && i == 1) check_eq("sw3ff_j1", 64'(dut.u_ksa.j_r), 64'd4);
            wait_state(WRITEI, ok);
            if (!ok) return;
            check_eq("writei", {dut.mem_addr_s, dut.mem_data_s, dut.mem_wren_s, LEDR[1:0]},
                     {8'(i), 8'(sj), 1'b1, 2'b10});
            @(negedge CLOCK_50);
            check_eq("writej", {4'(dut.u_ksa.state_r), dut.mem_addr_s, dut.mem_data_s,
                                dut.u_ksa.temp_i_r, dut.mem_wren_s},
                     {4'(WRITEJ), 8'(jn), 8'(si), 8'(si), 1'b1});
            s_model[i]  = sj;
            s_model[jn] = si;
            j = jn;
        end
        if (n_iter < 256) return;
        wait_state(DONE, ok);
        if (!ok) return;
        check_eq("done_ledr", 64'(LEDR), 64'b11);
        check_eq("done_wren", 64'(dut.mem_wren_s), 64'd0);
        repeat (5) @(negedge CLOCK_50);
        check_eq("done_hold", {4'(dut.u_ksa.state_r), LEDR}, {4'(DONE), 10'b11});
        check_eq("done_hex", {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}, {6{7'h7F}});
        bad  = 0;
        seen = 0;
        for (int k = 0; k < 256; k++) hit[k] = 1'b0;
        for (int k = 0; k < 256; k++) begin
            if (int'(dut.mem_r[k]) != s_model[k]) bad++;
            if (!hit[dut.mem_r[k]]) seen++;
            hit[dut.mem_r[k]] = 1'b1;
        end
        check_eq("final_s_errs", 64'(bad), 64'd0);
        check_eq("perm_distinct", 64'(seen), 64'd256);
    endtask

    initial begin
        logic [9:0] sw_rand;
        sw_rand = 10'($urandom_range(1, 1022));

        do_reset(10'h000);
        run_init();
        run_ksa(256);

        do_reset(10'h3FF);
        run_init();
        run_ksa(256);

        do_reset(sw_rand);
        run_init();
        run_ksa(100);
        do_reset(sw_rand);
        run_init();
        run_ksa(256);

        do_reset(10'($urandom_range(0, 1023)));
        run_init();
        run_ksa(256);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/arc4_init_ksa_top.md
Name: arc4_init_ksa_top

Overview:
- FPGA top level for ARC4 stage 2: owns a 256x8 state memory S.
- After reset it runs the init pass (S[i]=i), then the ARC4 key-scheduling algorithm (KSA) using a 24-bit key built from the switches.
- It then halts in DONE, leaving the scrambled S in memory for later stages (PRGA/cracking).
- Board I/O follows the DE1-SoC top-level port set.

Parameters:
- KEY_BYTES, 3, key length in bytes; key byte index = i mod KEY_BYTES.
- MEM_DEPTH, 256, state memory depth (8-bit address, wraps mod 256).

Ports:
- CLOCK_50  in  1  single system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset; sampled on CLOCK_50.
- KEY  in  4  push buttons; unused (board compatibility).
- SW  in  10  key source: key[23:0] = {14'b0, SW[9:0]}.
- HEX0..HEX5  out  7 each  seven-segment outputs, active-low; all drive 7'h7F (blank).
- LEDR  out  10  LEDR[0]=ksa_done, LEDR[1]=init_done, others 0.

Behaviour:
- Memory S: single-port, 8-bit addr, 8-bit wrdata, wren.
  - Write takes effect on the clock edge where wren=1.
  - Read has 1-cycle latency: rddata is valid the cycle after addr is presented.
- Observable internal nets: state, init_done, addr, data (write data), wren, i, j, temp_i.
- While reset=1:
  - Enter INIT with counter=0, i=0, j=0, temp_i=0.
  - Clear init_done and ksa_done; wren=0.
  - Asserting reset mid-operation restarts from INIT; memory contents are not cleared, only rewritten.
- INIT:
  - Each cycle drive addr=counter, data=counter, wren=1; counter increments.
  - After writing address 255, set init_done=1 and go to READI.
  - Exactly 256 write cycles; S[k]=k.
- KSA states, with addr/wren registered per state:
  - READI: addr=i, wren=0.
  - WAITI: addr held.
  - GETJ: temp_i<=rddata; j<=(j+rddata+keybyte(i)) mod 256.
  - READJ: addr=j (new value), wren=0.
  - WAITJ: addr held.
  - WRITEI: addr=i, data=rddata (old S[j]), wren=1.
  - WRITEJ: addr=j, data=temp_i, wren=1. Then if i==255 go to DONE, else i<=i+1 and go to READI.
- keybyte(i):
  - i mod 3 = 0 -> key[23:16]
  - i mod 3 = 1 -> key[15:8]
  - i mod 3 = 2 -> key[7:0]
- Required observations:
  - One cycle after entering GETJ, addr==j.
  - In WRITEI, addr==i.
  - In WRITEJ, data==temp_i.
- i==j case: WRITEI writes S[i] back unchanged, WRITEJ rewrites temp_i; net S unchanged.
- Arithmetic: all 8-bit, modulo 256, carries discarded.
- SW is sampled continuously; it must be held stable from reset release to DONE.
- DONE: ksa_done=1, wren=0, stay until reset.
- Total latency from reset release: 256 + 7*256 cycles (plus 1 transition cycle).

Decomposition:
- Package arc4_pkg: state enum (INIT, READI, WAITI, GETJ, READJ, WAITJ, WRITEI, WRITEJ, DONE), MEM_DEPTH, KEY_BYTES, key-byte select function.
- One natural sub-module: arc4_ksa (i/j/temp_i datapath + KSA FSM, memory-port interface, start/done handshake).
- Top level holds init counter, memory instance (inferred or vendor single-port RAM) and port mux.

Test Plan:
- Reset held 1 cycle, then released -> 256 consecutive cycles with wren=1, addr=data=0..255; afterwards S[k]=k for all k, init_done=1.
- SW=0x000, i=0 -> j=0, S unchanged; i=1 -> j=1; i=2 -> j=3, giving S[2]=3, S[3]=2.
- SW=0x3FF (key 00,03,FF), i=0 -> j=0; i=1 -> j=4, giving S[1]=4, S[4]=1.
- Every KSA iteration: addr==j one cycle after GETJ; addr==i in WRITEI; data==temp_i in WRITEJ; final S is a permutation of 0..255 and ksa_done=1 after i=255.
- Reset asserted mid-KSA (e.g. i=100) -> returns to INIT, flags clear, full init+KSA rerun yields the same final S as an uninterrupted run.
- HEX0..HEX5 stay 7'h7F throughout; LEDR[1:0] track init_done/ksa_done.
